// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI slave port between MASTERS requesters.
// One outstanding transaction; a response timeout frees the bus from a dead slave.
module obi_rr_arbiter #(
  parameter int MASTERS = 3,
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        master_req_i    [MASTERS],
  output logic        master_gnt_o    [MASTERS],
  output logic        master_rvalid_o [MASTERS],
  output logic        master_err_o    [MASTERS],
  input  logic        master_we_i     [MASTERS],
  input  logic [3:0]  master_be_i     [MASTERS],
  input  logic [31:0] master_addr_i   [MASTERS],
  input  logic [31:0] master_wdata_i  [MASTERS],
  output logic [31:0] master_rdata_o  [MASTERS],
  output logic        slave_req_o,
  input  logic        slave_gnt_i,
  input  logic        slave_rvalid_i,
  output logic        slave_we_o,
  output logic [3:0]  slave_be_o,
  output logic [31:0] slave_addr_o,
  output logic [31:0] slave_wdata_o,
  input  logic [31:0] slave_rdata_i
);
  localparam int PW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam logic [7:0] TLAST = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [PW-1:0] winner;
  logic          win_vld;
  logic          timeout_hit;
  logic [PW-1:0] ptr_next;

  // Descending scan so the candidate closest to ptr is assigned last and wins.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    win_vld = 1'b0;
    for (int i = MASTERS - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % MASTERS;
      if (master_req_i[idx]) begin
        winner  = PW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  assign timeout_hit = TO_EN && (tcnt_q == TLAST) && !slave_rvalid_i;
  assign ptr_next    = (int'(owner_q) == MASTERS - 1) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          owner_d = winner;
          tcnt_d  = '0;
          state_d = slave_gnt_i ? WAIT_RSP : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        // A master withdrawing its request forfeits the slot without moving ptr.
        if (!master_req_i[owner_q]) begin
          state_d = IDLE;
        end else if (slave_gnt_i) begin
          tcnt_d  = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        tcnt_d = tcnt_q + 8'd1;
        if (slave_rvalid_i || timeout_hit) begin
          ptr_d   = ptr_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic [PW-1:0] sel;
    logic          drive;
    sel           = (state_q == IDLE) ? winner : owner_q;
    drive         = ((state_q == IDLE) && win_vld) || (state_q == WAIT_GNT);
    slave_req_o   = 1'b0;
    slave_we_o    = 1'b0;
    slave_be_o    = '0;
    slave_addr_o  = '0;
    slave_wdata_o = '0;
    for (int i = 0; i < MASTERS; i++) begin
      master_gnt_o[i]    = 1'b0;
      master_rvalid_o[i] = 1'b0;
      master_err_o[i]    = 1'b0;
      master_rdata_o[i]  = ((state_q == WAIT_RSP) && timeout_hit) ? 32'h0 : slave_rdata_i;
    end
    if (drive) begin
      slave_req_o   = master_req_i[sel];
      slave_we_o    = master_we_i[sel];
      slave_be_o    = master_be_i[sel];
      slave_addr_o  = master_addr_i[sel];
      slave_wdata_o = master_wdata_i[sel];
      master_gnt_o[sel] = master_req_i[sel] && slave_gnt_i;
    end
    if (state_q == WAIT_RSP && (slave_rvalid_i || timeout_hit)) begin
      master_rvalid_o[owner_q] = 1'b1;
      master_err_o[owner_q]    = timeout_hit;
    end
  end

endmodule
